udp_addr_filter: RTL and testbench

//   Receive-side destination-address filter. Sits directly downstream of crc_rx and consumes its
//   CRC-validated byte stream (to_udp*). Compares the leading ADDR_BYTES of each frame against

---
 rtl/udp_filter_pkg.sv | 27 ++
 rtl/udp_addr_filter_sat_counter.sv | 37 +++
 rtl/udp_addr_filter.sv | 195 +++++++++++++++++++
 tb/tb_udp_addr_filter.sv | 473 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/udp_filter_pkg.sv
// Shared types and helpers for the receive-side destination-address filter.
// Optional feature macro: ADDR_BCAST_EN (also accept an all-ones header).
package udp_filter_pkg;

    localparam int BYTE_W         = 8;
    localparam int MAX_ADDR_BYTES = 16;
    localparam int ADDR_MAX_W     = MAX_ADDR_BYTES * BYTE_W;

    typedef enum logic [1:0] {
        IDLE,
        HDR,
        FWD,
        DROP
    } state_e;

    // Header byte i of an n-byte address, most significant byte first.
    function automatic logic [BYTE_W-1:0] hdr_byte(
        input logic [ADDR_MAX_W-1:0] addr,
        input int unsigned           n,
        input int unsigned           i
    );
        logic [ADDR_MAX_W-1:0] sh;
        sh = addr >> ((n - 1 - i) * BYTE_W);
        return sh[BYTE_W-1:0];
    endfunction

endpackage

// File: rtl/udp_addr_filter_sat_counter.sv
// Saturating up-counter with +1 and +2 increments and synchronous reset.
// Optional feature macro of the parent design: ADDR_BCAST_EN (unused here).
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         inc2,
    output logic [W-1:0] count
);

    localparam logic [W-1:0] MAX = '1;

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc2) begin
            count_d = (count_q >= MAX - W'(1)) ? MAX : count_q + W'(2);
        end else if (inc) begin
            count_d = (count_q == MAX) ? MAX : count_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/udp_addr_filter.sv
// Destination-address filter: strips a matching header and forwards the payload.
// Optional feature macro: ADDR_BCAST_EN (also accept an all-ones header).
module udp_addr_filter
    import udp_filter_pkg::*;
#(
    parameter int ADDR_BYTES = 6,
    parameter int COUNT_W    = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [7:0]              udp_rx,
    input  logic                    udp_rx_valid,
    input  logic                    udp_rx_first,
    input  logic                    udp_rx_last,
    input  logic [ADDR_BYTES*8-1:0] local_addr,
    output logic [7:0]              to_udp,
    output logic                    to_udp_valid,
    output logic                    to_udp_first,
    output logic                    to_udp_last,
    output logic                    frame_abort,
    output logic [COUNT_W-1:0]      accept_count,
    output logic [COUNT_W-1:0]      drop_count
);

    localparam int CNT_W = $clog2(ADDR_BYTES + 1);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(ADDR_BYTES - 1);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    hdr_cnt_q, hdr_cnt_d;
    logic                match_q, match_d;
    logic                pay_first_q, pay_first_d;
    logic [7:0]          to_udp_q, to_udp_d;
    logic                valid_q, valid_d;
    logic                first_q, first_d;
    logic                last_q, last_d;
    logic                abort_q, abort_d;
    logic                acc_inc, drop_inc, drop_inc2;

    logic [ADDR_MAX_W-1:0] addr_ext;
    logic                  eq0, eqn;
    logic                  next_match;
    logic                  start_hit, next_hit;

    assign addr_ext   = ADDR_MAX_W'(local_addr);
    assign eq0        = udp_rx == hdr_byte(addr_ext, ADDR_BYTES, 0);
    assign eqn        = udp_rx == hdr_byte(addr_ext, ADDR_BYTES,
                                           32'(hdr_cnt_q));
    assign next_match = match_q & eqn;

`ifdef ADDR_BCAST_EN
    logic bcast_q, bcast_d;
    logic is_ff;
    logic next_bcast;

    assign is_ff      = udp_rx == 8'hFF;
    assign next_bcast = bcast_q & is_ff;
    assign start_hit  = eq0 | is_ff;
    assign next_hit   = next_match | next_bcast;
`else
    assign start_hit  = eq0;
    assign next_hit   = next_match;
`endif

    always_comb begin
        state_d     = state_q;
        hdr_cnt_d   = hdr_cnt_q;
        match_d     = match_q;
        pay_first_d = pay_first_q;
        to_udp_d    = to_udp_q;
        valid_d     = 1'b0;
        first_d     = 1'b0;
        last_d      = 1'b0;
        abort_d     = 1'b0;
        acc_inc     = 1'b0;
        drop_inc    = 1'b0;
        drop_inc2   = 1'b0;
`ifdef ADDR_BCAST_EN
        bcast_d     = bcast_q;
`endif
        if (udp_rx_valid) begin
            if (udp_rx_first) begin
                // A new first byte always restarts header matching.
                abort_d   = state_q == FWD;
                hdr_cnt_d = CNT_W'(1);
                match_d   = eq0;
`ifdef ADDR_BCAST_EN
                bcast_d   = is_ff;
`endif
                if (udp_rx_last) begin
                    state_d   = IDLE;
                    drop_inc2 = state_q != IDLE;
                    drop_inc  = state_q == IDLE;
                end else begin
                    drop_inc = state_q != IDLE;
                    if (ADDR_BYTES == 1) begin
                        state_d     = start_hit ? FWD : DROP;
                        pay_first_d = 1'b1;
                    end else begin
                        state_d = HDR;
                    end
                end
            end else begin
                unique case (state_q)
                    IDLE: begin
                    end
                    HDR: begin
                        hdr_cnt_d = hdr_cnt_q + CNT_W'(1);
                        match_d   = next_match;
`ifdef ADDR_BCAST_EN
                        bcast_d   = next_bcast;
`endif
                        if (udp_rx_last) begin
                            drop_inc = 1'b1;
                            state_d  = IDLE;
                        end else if (hdr_cnt_q == LAST_IDX) begin
                            state_d     = next_hit ? FWD : DROP;
                            pay_first_d = 1'b1;
                        end
                    end
                    FWD: begin
                        valid_d     = 1'b1;
                        to_udp_d    = udp_rx;
                        first_d     = pay_first_q;
                        pay_first_d = 1'b0;
                        if (udp_rx_last) begin
                            last_d  = 1'b1;
                            acc_inc = 1'b1;
                            state_d = IDLE;
                        end
                    end
                    DROP: begin
                        if (udp_rx_last) begin
                            drop_inc = 1'b1;
                            state_d  = IDLE;
                        end
                    end
                    default: state_d = IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            hdr_cnt_q   <= '0;
            match_q     <= 1'b0;
            pay_first_q <= 1'b0;
            to_udp_q    <= '0;
            valid_q     <= 1'b0;
            first_q     <= 1'b0;
            last_q      <= 1'b0;
            abort_q     <= 1'b0;
`ifdef ADDR_BCAST_EN
            bcast_q     <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            hdr_cnt_q   <= hdr_cnt_d;
            match_q     <= match_d;
            pay_first_q <= pay_first_d;
            to_udp_q    <= to_udp_d;
            valid_q     <= valid_d;
            first_q     <= first_d;
            last_q      <= last_d;
            abort_q     <= abort_d;
`ifdef ADDR_BCAST_EN
            bcast_q     <= bcast_d;
`endif
        end
    end

    sat_counter #(.W(COUNT_W)) u_acc_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (acc_inc),
        .inc2  (1'b0),
        .count (accept_count)
    );

    sat_counter #(.W(COUNT_W)) u_drop_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (drop_inc),
        .inc2  (drop_inc2),
        .count (drop_count)
    );

    assign to_udp       = to_udp_q;
    assign to_udp_valid = valid_q;
    assign to_udp_first = first_q;
    assign to_udp_last  = last_q;
    assign frame_abort  = abort_q;

endmodule

// File: tb/tb_udp_addr_filter.sv
// Randomized self-checking bench for udp_addr_filter with a frame-level model.
// Honours ADDR_BCAST_EN when the design is built with it.
module tb_udp_addr_filter;

    localparam int AB   = 6;
    localparam int CW   = 8;
    localparam int MAXC = (1 << CW) - 1;
    localparam logic [AB*8-1:0] LADDR = 48'h0A1B2C3D4E5F;
`ifdef ADDR_BCAST_EN
    localparam bit BCAST = 1'b1;
`else
    localparam bit BCAST = 1'b0;
`endif

    typedef logic [7:0] bq_t[$];

    logic            clk;
    logic            rst;
    logic [7:0]      udp_rx;
    logic            udp_rx_valid;
    logic            udp_rx_first;
    logic            udp_rx_last;
    logic [AB*8-1:0] local_addr;
    logic [7:0]      to_udp;
    logic            to_udp_valid;
    logic            to_udp_first;
    logic            to_udp_last;
    logic            frame_abort;
    logic [CW-1:0]   accept_count;
    logic [CW-1:0]   drop_count;

    udp_addr_filter #(.ADDR_BYTES(AB), .COUNT_W(CW)) dut (
        .clk          (clk),
        .rst          (rst),
        .udp_rx       (udp_rx),
        .udp_rx_valid (udp_rx_valid),
        .udp_rx_first (udp_rx_first),
        .udp_rx_last  (udp_rx_last),
        .local_addr   (local_addr),
        .to_udp       (to_udp),
        .to_udp_valid (to_udp_valid),
        .to_udp_first (to_udp_first),
        .to_udp_last  (to_udp_last),
        .frame_abort  (frame_abort),
        .accept_count (accept_count),
        .drop_count   (drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass;
    int n_total;
    int exp_acc;
    int exp_drop;
    int aborts;
    int abort_bad;
    int strobe_bad;
    logic [9:0] got_q[$];
    logic [9:0] exp_q[$];

    always @(negedge clk) begin
        if (!rst) begin
            if (to_udp_valid)
                got_q.push_back({to_udp_first, to_udp_last, to_udp});
            if (frame_abort)
                aborts++;
            if (frame_abort && to_udp_valid)
                abort_bad++;
            if (!to_udp_valid && (to_udp_first || to_udp_last))
                strobe_bad++;
        end
    end

    function automatic int sat(input int x);
        return (x > MAXC) ? MAXC : x;
    endfunction

    function automatic bit accepts(input bq_t f);
        logic [AB*8-1:0] h;
        if (f.size() <= AB)
            return 1'b0;
        h = '0;
        for (int i = 0; i < AB; i++)
            h = (h << 8) | (AB*8)'(f[i]);
        return (h == LADDR) || (BCAST && h == '1);
    endfunction

    function automatic bq_t good_hdr();
        bq_t q;
        logic [AB*8-1:0] a;
        a = LADDR;
        for (int i = AB - 1; i >= 0; i--)
            q.push_back(a[i*8 +: 8]);
        return q;
    endfunction

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [7:0] b, input bit f, input bit l);
        udp_rx       = b;
        udp_rx_valid = 1'b1;
        udp_rx_first = f;
        udp_rx_last  = l;
        @(posedge clk);
        #1;
        udp_rx_valid = 1'b0;
        udp_rx_first = 1'b0;
        udp_rx_last  = 1'b0;
        udp_rx       = 8'($urandom);
    endtask

    task automatic drive_frame(input bq_t f, input int gmax);
        int n;
        n = f.size();
        for (int i = 0; i < n; i++) begin
            send(f[i], i == 0, i == n - 1);
            if (i != n - 1 && gmax > 0)
                idle($urandom_range(gmax, 0));
        end
        if (accepts(f)) begin
            for (int i = AB; i < n; i++)
                exp_q.push_back({i == AB, i == n - 1, f[i]});
            exp_acc++;
        end else begin
            exp_drop++;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        exp_acc  = 0;
        exp_drop = 0;
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle(3);
        n_total++;
        if ({to_udp_valid, to_udp_first, to_udp_last, frame_abort} !== 4'b0)
            $display("FAIL reset_strobes got=%b want=0000",
                     {to_udp_valid, to_udp_first, to_udp_last, frame_abort});
        else n_pass++;
        n_total++;
        if (accept_count !== CW'(0))
            $display("FAIL reset_acc got=%0d want=0", accept_count);
        else n_pass++;
        n_total++;
        if (drop_count !== CW'(0))
            $display("FAIL reset_drop got=%0d want=0", drop_count);
        else n_pass++;
        rst = 1'b0;
        exp_acc  = 0;
        exp_drop = 0;
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic test_match();
        bq_t f;
        logic [7:0] pay[3];
        logic [10:0] want;
        pay = '{8'h11, 8'h22, 8'h33};
        f = good_hdr();
        for (int i = 0; i < AB; i++)
            send(f[i], i == 0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            send(pay[i], 1'b0, i == 2);
            want = {1'b1, i == 0, i == 2, pay[i]};
            n_total++;
            if ({to_udp_valid, to_udp_first, to_udp_last, to_udp} !== want)
                $display("FAIL match_byte%0d got=%h want=%h", i,
                         {to_udp_valid, to_udp_first, to_udp_last, to_udp},
                         want);
            else n_pass++;
        end
        exp_acc++;
        idle(2);
        n_total++;
        if (to_udp_valid !== 1'b0)
            $display("FAIL match_quiet got=%b want=0", to_udp_valid);
        else n_pass++;
        n_total++;
        if (accept_count !== CW'(sat(exp_acc)))
            $display("FAIL match_acc got=%0d want=%0d", accept_count,
                     sat(exp_acc));
        else n_pass++;
        n_total++;
        if (drop_count !== CW'(sat(exp_drop)))
            $display("FAIL match_drop got=%0d want=%0d", drop_count,
                     sat(exp_drop));
        else n_pass++;
        got_q.delete();
    endtask

    task automatic test_mismatch_runt();
        bq_t f;
        f = good_hdr();
        f[AB-1] = 8'h60;
        f.push_back(8'h11);
        f.push_back(8'h22);
        drive_frame(f, 0);
        idle(2);
        n_total++;
        if (got_q.size() != 0 || drop_count !== CW'(sat(exp_drop)))
            $display("FAIL mismatch got=%0d/%0d want=0/%0d", got_q.size(),
                     drop_count, sat(exp_drop));
        else n_pass++;
        f = '{8'h0A, 8'h1B, 8'h2C};
        drive_frame(f, 1);
        f = good_hdr();
        drive_frame(f, 0);
        idle(2);
        n_total++;
        if (got_q.size() != 0 || drop_count !== CW'(sat(exp_drop)))
            $display("FAIL runt got=%0d/%0d want=0/%0d", got_q.size(),
                     drop_count, sat(exp_drop));
        else n_pass++;
    endtask

    task automatic test_interrupt();
        bq_t f;
        int a0;
        logic [7:0] p0, p1;
        got_q.delete();
        exp_q.delete();
        a0 = aborts;
        p0 = 8'($urandom);
        p1 = 8'($urandom);
        f = good_hdr();
        for (int i = 0; i < AB; i++) begin
            send(f[i], i == 0, 1'b0);
            idle($urandom_range(3, 0));
        end
        send(p0, 1'b0, 1'b0);
        idle($urandom_range(3, 0));
        send(p1, 1'b0, 1'b0);
        idle($urandom_range(3, 0));
        exp_q.push_back({2'b10, p0});
        exp_q.push_back({2'b00, p1});
        exp_drop++;
        f = good_hdr();
        for (int i = 0; i < 4; i++)
            f.push_back(8'($urandom));
        drive_frame(f, 3);
        idle(3);
        n_total++;
        if (aborts - a0 != 1 || abort_bad != 0)
            $display("FAIL abort_pulse got=%0d bad=%0d want=1 bad=0",
                     aborts - a0, abort_bad);
        else n_pass++;
        n_total++;
        if (got_q.size() != exp_q.size())
            $display("FAIL intr_count got=%0d want=%0d", got_q.size(),
                     exp_q.size());
        else n_pass++;
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_total++;
            if (got_q[i] !== exp_q[i])
                $display("FAIL intr_byte%0d got=%h want=%h", i, got_q[i],
                         exp_q[i]);
            else n_pass++;
        end
        n_total++;
        if (drop_count !== CW'(sat(exp_drop)) ||
            accept_count !== CW'(sat(exp_acc)))
            $display("FAIL intr_counts got=%0d/%0d want=%0d/%0d",
                     accept_count, drop_count, sat(exp_acc), sat(exp_drop));
        else n_pass++;
    endtask

    task automatic test_bcast();
        bq_t f;
        got_q.delete();
        exp_q.delete();
        for (int i = 0; i < AB; i++)
            f.push_back(8'hFF);
        f.push_back(8'hAA);
        drive_frame(f, 0);
        idle(2);
        n_total++;
        if (got_q.size() != exp_q.size() ||
            (exp_q.size() == 1 && got_q[0] !== exp_q[0]))
            $display("FAIL bcast got=%0d items want=%0d", got_q.size(),
                     exp_q.size());
        else n_pass++;
        n_total++;
        if (accept_count !== CW'(sat(exp_acc)) ||
            drop_count !== CW'(sat(exp_drop)))
            $display("FAIL bcast_counts got=%0d/%0d want=%0d/%0d",
                     accept_count, drop_count, sat(exp_acc), sat(exp_drop));
        else n_pass++;
    endtask

    task automatic test_double_drop();
        bq_t f;
        int a0;
        a0 = aborts;
        f = good_hdr();
        send(f[0], 1'b1, 1'b0);
        send(f[1], 1'b0, 1'b0);
        send(8'h55, 1'b1, 1'b1);
        exp_drop += 2;
        idle(1);
        n_total++;
        if (drop_count !== CW'(sat(exp_drop)))
            $display("FAIL dbl_hdr got=%0d want=%0d", drop_count,
                     sat(exp_drop));
        else n_pass++;
        got_q.delete();
        for (int i = 0; i < AB; i++)
            send(f[i], i == 0, 1'b0);
        send(8'h77, 1'b0, 1'b0);
        send(8'h0A, 1'b1, 1'b1);
        exp_drop += 2;
        idle(2);
        n_total++;
        if (drop_count !== CW'(sat(exp_drop)) || aborts - a0 != 1 ||
            got_q.size() != 1)
            $display("FAIL dbl_fwd got=%0d/%0d/%0d want=%0d/1/1", drop_count,
                     aborts - a0, got_q.size(), sat(exp_drop));
        else n_pass++;
        got_q.delete();
    endtask

    task automatic test_random();
        bq_t f;
        int len, kind, k;
        got_q.delete();
        exp_q.delete();
        for (int n = 0; n < 60; n++) begin
            kind = $urandom_range(3, 0);
            len  = $urandom_range(AB + 4, 1);
            f = good_hdr();
            if (kind == 1) begin
                k = $urandom_range(AB - 1, 0);
                f[k] = f[k] ^ 8'($urandom_range(255, 1));
            end else if (kind >= 2) begin
                for (int i = 0; i < AB; i++)
                    f[i] = (kind == 2) ? 8'hFF : 8'($urandom);
            end
            while (f.size() < len)
                f.push_back(8'($urandom));
            while (f.size() > len)
                void'(f.pop_back());
            drive_frame(f, 3);
            if ($urandom_range(3, 0) == 0)
                send(8'($urandom), 1'b0, 1'($urandom_range(1, 0)));
            idle($urandom_range(2, 0));
        end
        idle(3);
        n_total++;
        if (got_q.size() != exp_q.size())
            $display("FAIL rand_count got=%0d want=%0d", got_q.size(),
                     exp_q.size());
        else n_pass++;
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_total++;
            if (got_q[i] !== exp_q[i])
                $display("FAIL rand_byte%0d got=%h want=%h", i, got_q[i],
                         exp_q[i]);
            else n_pass++;
        end
        n_total++;
        if (accept_count !== CW'(sat(exp_acc)))
            $display("FAIL rand_acc got=%0d want=%0d", accept_count,
                     sat(exp_acc));
        else n_pass++;
        n_total++;
        if (drop_count !== CW'(sat(exp_drop)))
            $display("FAIL rand_drop got=%0d want=%0d", drop_count,
                     sat(exp_drop));
        else n_pass++;
        n_total++;
        if (strobe_bad != 0)
            $display("FAIL rand_strobes got=%0d want=0", strobe_bad);
        else n_pass++;
    endtask

    task automatic test_reset_mid_and_sat();
        bq_t f;
        f = good_hdr();
        for (int i = 0; i < AB; i++)
            send(f[i], i == 0, 1'b0);
        send(8'h99, 1'b0, 1'b0);
        rst = 1'b1;
        send(8'h98, 1'b0, 1'b0);
        n_total++;
        if ({to_udp_valid, to_udp_first, to_udp_last, frame_abort} !== 4'b0)
            $display("FAIL rst_mid_out got=%b want=0000",
                     {to_udp_valid, to_udp_first, to_udp_last, frame_abort});
        else n_pass++;
        n_total++;
        if (accept_count !== CW'(0) || drop_count !== CW'(0))
            $display("FAIL rst_mid_cnt got=%0d/%0d want=0/0", accept_count,
                     drop_count);
        else n_pass++;
        rst = 1'b0;
        exp_acc  = 0;
        exp_drop = 0;
        got_q.delete();
        exp_q.delete();
        f.push_back(8'h42);
        for (int n = 0; n < MAXC + 2; n++)
            drive_frame(f, 0);
        idle(1);
        n_total++;
        if (accept_count !== CW'(sat(exp_acc)))
            $display("FAIL acc_sat got=%0d want=%0d", accept_count,
                     sat(exp_acc));
        else n_pass++;
        got_q.delete();
        exp_q.delete();
        for (int n = 0; n < MAXC / 2; n++) begin
            send(f[0], 1'b1, 1'b0);
            send(8'h01, 1'b1, 1'b1);
            exp_drop += 2;
        end
        idle(1);
        n_total++;
        if (drop_count !== CW'(sat(exp_drop)))
            $display("FAIL drop_near got=%0d want=%0d", drop_count,
                     sat(exp_drop));
        else n_pass++;
        send(f[0], 1'b1, 1'b0);
        send(8'h01, 1'b1, 1'b1);
        exp_drop += 2;
        idle(1);
        n_total++;
        if (drop_count !== CW'(sat(exp_drop)))
            $display("FAIL drop_sat got=%0d want=%0d", drop_count,
                     sat(exp_drop));
        else n_pass++;
    endtask

    initial begin
        n_pass       = 0;
        n_total      = 0;
        exp_acc      = 0;
        exp_drop     = 0;
        aborts       = 0;
        abort_bad    = 0;
        strobe_bad   = 0;
        rst          = 1'b1;
        udp_rx       = '0;
        udp_rx_valid = 1'b0;
        udp_rx_first = 1'b0;
        udp_rx_last  = 1'b0;
        local_addr   = LADDR;
        idle(1);
        test_reset();
        test_match();
        test_mismatch_runt();
        test_interrupt();
        test_bcast();
        test_double_drop();
        do_reset();
        test_random();
        test_reset_mid_and_sat();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
